// File: rtl/alu_sequencer_if.sv
// Command, ALU-drive and result bundle between an alu_sequencer and its environment.
// master: drives commands, supplies alu_out, accepts results.
// slave: the sequencer side; drives cmd_ready, the ALU operands and the result port.
interface alu_sequencer_if #(
    parameter int N = 4
);
    logic           cmd_valid;
    logic           cmd_ready;
    logic [3:0]     cmd_op;
    logic [N-1:0]   cmd_a;
    logic [N-1:0]   cmd_b;
    logic           cmd_use_acc;

    logic [N-1:0]   operand1;
    logic [N-1:0]   operand2;
    logic [3:0]     operation;
    logic [2*N-1:0] alu_out;

    logic           res_valid;
    logic           res_ready;
    logic [2*N-1:0] res_data;
    logic [3:0]     res_op;
    logic           res_err;
    logic           busy;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, alu_out, res_ready,
        input  cmd_ready, operand1, operand2, operation,
               res_valid, res_data, res_op, res_err, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, alu_out, res_ready,
        output cmd_ready, operand1, operand2, operation,
               res_valid, res_data, res_op, res_err, busy
    );
endinterface

// File: rtl/alu_sequencer.sv
// Purpose: queues ALU commands, drives registered operands to an external combinational ALU,
//          captures its result and keeps an accumulator for chained operations.
// Latency: result valid 2 edges after a push into an idle, empty sequencer; 1 result per 3 cycles.
// Backpressure: cmd_ready = FIFO not full; res_* held stable until res_ready, nothing dropped.
//
// Ports: clk, rst (synchronous, active-high); bus (slave modport) carries the cmd_* push port,
// the operand1/operand2/operation/alu_out ALU connection, the res_* result port and busy.
module alu_sequencer #(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    alu_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic [3:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         use_acc;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_RESP
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    cmd_t           mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [AW:0]    count_q;
    logic [AW:0]    count_d;
    cmd_t           push_entry;
    cmd_t           head;
    logic           fifo_empty;
    logic           push;
    logic           pop;

    state_t         state_q;
    logic [N-1:0]   operand1_q;
    logic [N-1:0]   operand2_q;
    logic [3:0]     operation_q;
    logic           err_q;
    logic [2*N-1:0] acc_q;
    logic           res_valid_q;
    logic [2*N-1:0] res_data_q;
    logic [3:0]     res_op_q;
    logic           res_err_q;

    assign push_entry = {bus.cmd_op, bus.cmd_a, bus.cmd_b, bus.cmd_use_acc};
    assign head       = mem_q[rd_ptr_q];
    assign fifo_empty = (count_q == '0);

    // Ready comes from the registered count only, so a pop on the same edge
    // never opens a slot for a push into a full FIFO.
    assign bus.cmd_ready = (count_q < FULL_CNT);
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign pop           = (state_q == S_IDLE) && !fifo_empty;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // ------------------------------------------------------------------
    // Issue / capture FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            operand1_q  <= '0;
            operand2_q  <= '0;
            operation_q <= '0;
            err_q       <= 1'b0;
            acc_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= '0;
            res_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        operation_q <= head.op;
                        operand2_q  <= head.b;
                        // acc holds the last delivered result; only its low half feeds back.
                        operand1_q  <= head.use_acc ? acc_q[N-1:0] : head.a;
                        // Divide/modulo by zero is resolved here; the ALU output is ignored.
                        err_q       <= ((head.op == 4'b0011) || (head.op == 4'b0100))
                                       && (head.b == '0);
                        state_q     <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    res_data_q  <= err_q ? '0 : bus.alu_out;
                    res_op_q    <= operation_q;
                    res_err_q   <= err_q;
                    res_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        res_err_q   <= 1'b0;
                        acc_q       <= res_data_q;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.operand1  = operand1_q;
    assign bus.operand2  = operand2_q;
    assign bus.operation = operation_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_op    = res_op_q;
    assign bus.res_err   = res_err_q;
    assign bus.busy      = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed scenarios plus a randomized run against a
// command-queue reference model with an accumulator.
module tb_alu_sequencer;
    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int W     = 2 * N;

    typedef struct {
        logic [3:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         ua;
    } cmd_s;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    logic [W-1:0] acc_m = '0;
    cmd_s q_cmd[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_sequencer_if #(.N(N)) bus ();

    alu_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stand-in for the combinational ALU: unsigned, result 2N bits wide.
    function automatic logic [W-1:0] alu_ref(input logic [3:0] op, input logic [N-1:0] a,
                                             input logic [N-1:0] b);
        case (op)
            4'd0:    return W'(a) + W'(b);
            4'd1:    return W'(a) - W'(b);
            4'd2:    return W'(a) * W'(b);
            4'd3:    return (b == 0) ? '0 : W'(a / b);
            4'd4:    return (b == 0) ? '0 : W'(a % b);
            4'd5:    return W'(a & b);
            4'd6:    return W'(a | b);
            4'd7:    return W'(a ^ b);
            default: return '0;
        endcase
    endfunction

    assign bus.alu_out = alu_ref(bus.operation, bus.operand1, bus.operand2);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents one command and holds it until accepted; returns at accept edge + 1.
    task automatic push_cmd(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic ua, output bit ok);
        ok = 1'b0;
        bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_use_acc = ua;
        bus.cmd_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (bus.cmd_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        bus.cmd_valid = 1'b0;
    endtask

    // Waits (bounded) for a result with res_ready already high; returns after the handshake edge.
    task automatic get_result(output bit ok, output logic [W-1:0] d, output logic [3:0] op,
                              output logic e);
        ok = 1'b0; d = '0; op = '0; e = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (bus.res_valid && bus.res_ready) begin
                ok = 1'b1; d = bus.res_data; op = bus.res_op; e = bus.res_err;
                tick();
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0;
        bus.cmd_use_acc = 1'b0; bus.res_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b want=1", bus.cmd_ready); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%b want=0", bus.res_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        checks++; if (bus.operand1 !== '0 || bus.operand2 !== '0 || bus.operation !== '0) begin
            errors++; $display("FAIL reset_operands got=%h/%h/%h want=0/0/0", bus.operand1, bus.operand2, bus.operation); end
        checks++; if (bus.res_data !== '0 || bus.res_op !== '0 || bus.res_err !== 1'b0) begin
            errors++; $display("FAIL reset_result got=%h/%h/%b want=0/0/0", bus.res_data, bus.res_op, bus.res_err); end
        acc_m = '0;
    endtask

    task automatic test_single_add;
        bit ok;
        bus.res_ready = 1'b1;
        push_cmd(4'b0000, 4'd7, 4'd9, 1'b0, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL add_push_accept got=%b want=1", ok); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL add_busy got=%b want=1", bus.busy); end
        tick();
        checks++; if (bus.operation !== 4'b0000 || bus.operand1 !== 4'd7 || bus.operand2 !== 4'd9) begin
            errors++; $display("FAIL add_drive got=%h/%h/%h want=0/7/9", bus.operation, bus.operand1, bus.operand2); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL add_valid_early got=%b want=0", bus.res_valid); end
        tick();
        checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h10 || bus.res_op !== 4'b0000 || bus.res_err !== 1'b0) begin
            errors++; $display("FAIL add_result got=v%b d%h op%h e%b want=v1 d10 op0 e0", bus.res_valid, bus.res_data, bus.res_op, bus.res_err); end
        tick();
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL add_valid_clear got=%b want=0", bus.res_valid); end
        acc_m = 8'h10;
    endtask

    task automatic test_acc_chain;
        bit ok; logic [W-1:0] d; logic [3:0] op; logic e;
        bus.res_ready = 1'b1;
        push_cmd(4'b0010, 4'd15, 4'd15, 1'b0, ok);
        get_result(ok, d, op, e);
        checks++; if (ok !== 1'b1 || d !== 8'hE1 || op !== 4'b0010) begin
            errors++; $display("FAIL chain_mul got=ok%b d%h op%h want=ok1 dE1 op2", ok, d, op); end
        push_cmd(4'b0000, 4'd9, 4'd2, 1'b1, ok);
        tick();
        checks++; if (bus.operand1 !== 4'd1) begin errors++; $display("FAIL chain_operand1 got=%h want=1", bus.operand1); end
        get_result(ok, d, op, e);
        checks++; if (ok !== 1'b1 || d !== 8'h03) begin errors++; $display("FAIL chain_add got=ok%b d%h want=ok1 d03", ok, d); end
        acc_m = 8'h03;
    endtask

    task automatic test_div_zero;
        bit ok; logic [W-1:0] d; logic [3:0] op; logic e;
        bus.res_ready = 1'b1;
        push_cmd(4'b0011, 4'd9, 4'd0, 1'b0, ok);
        get_result(ok, d, op, e);
        checks++; if (ok !== 1'b1 || e !== 1'b1 || d !== '0) begin
            errors++; $display("FAIL div0 got=ok%b e%b d%h want=ok1 e1 d00", ok, e, d); end
        checks++; if (bus.res_err !== 1'b0) begin errors++; $display("FAIL div0_err_clear got=%b want=0", bus.res_err); end
        push_cmd(4'b0011, 4'd9, 4'd2, 1'b0, ok);
        get_result(ok, d, op, e);
        checks++; if (ok !== 1'b1 || e !== 1'b0 || d !== 8'h04) begin
            errors++; $display("FAIL div_ok got=ok%b e%b d%h want=ok1 e0 d04", ok, e, d); end
        push_cmd(4'b0100, 4'd9, 4'd0, 1'b0, ok);
        get_result(ok, d, op, e);
        checks++; if (ok !== 1'b1 || e !== 1'b1 || d !== '0 || op !== 4'b0100) begin
            errors++; $display("FAIL mod0 got=ok%b e%b d%h op%h want=ok1 e1 d00 op4", ok, e, d, op); end
        // The error result zeroes the accumulator.
        push_cmd(4'b0000, 4'd9, 4'd3, 1'b1, ok);
        get_result(ok, d, op, e);
        checks++; if (ok !== 1'b1 || d !== 8'h03) begin errors++; $display("FAIL err_acc got=ok%b d%h want=ok1 d03", ok, d); end
        acc_m = 8'h03;
    endtask

    task automatic test_back_to_back;
        bit ok; bit pushed6; bit acc_now;
        int got;
        logic [W-1:0] rd [6];
        int rc [6];
        bus.res_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            push_cmd(4'b0000, N'(i), 4'd1, 1'b0, ok);
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_push%0d got=%b want=1", i, ok); end
        end
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_full got=%b want=0", bus.cmd_ready); end
        bus.cmd_op = 4'b0000; bus.cmd_a = 4'd6; bus.cmd_b = 4'd1; bus.cmd_use_acc = 1'b0;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (bus.cmd_ready !== 1'b0 || bus.res_valid !== 1'b1 || bus.res_data !== 8'h02) begin
            errors++; $display("FAIL bp_stall got=rdy%b v%b d%h want=rdy0 v1 d02", bus.cmd_ready, bus.res_valid, bus.res_data); end
        bus.res_ready = 1'b1;
        got = 0; pushed6 = 1'b0;
        for (int t = 0; t < 60 && got < 6; t++) begin
            acc_now = bus.cmd_valid && bus.cmd_ready;
            if (bus.res_valid) begin
                rd[got] = bus.res_data; rc[got] = cyc; got++;
            end
            tick();
            if (acc_now) begin bus.cmd_valid = 1'b0; pushed6 = 1'b1; end
        end
        bus.cmd_valid = 1'b0;
        checks++; if (got != 6 || !pushed6) begin errors++; $display("FAIL bp_drain got=%0d/%b want=6/1", got, pushed6); end
        for (int k = 0; k < got; k++) begin
            checks++; if (rd[k] !== W'(k + 2)) begin errors++; $display("FAIL bp_order%0d got=%h want=%h", k, rd[k], W'(k + 2)); end
            if (k > 0) begin
                checks++; if (rc[k] - rc[k-1] != 3) begin errors++; $display("FAIL bp_spacing%0d got=%0d want=3", k, rc[k] - rc[k-1]); end
            end
        end
        acc_m = 8'h07;
    endtask

    task automatic test_reset_mid_resp;
        bit ok; logic [W-1:0] d; logic [3:0] op; logic e;
        bus.res_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push_cmd(4'b0000, N'(i), 4'd1, 1'b0, ok);
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rst_push%0d got=%b want=1", i, ok); end
        end
        checks++; if (bus.res_valid !== 1'b1 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL rst_pre got=v%b busy%b want=v1 busy1", bus.res_valid, bus.busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL rst_flush got=v%b busy%b rdy%b want=v0 busy0 rdy1", bus.res_valid, bus.busy, bus.cmd_ready); end
        acc_m = '0;
        bus.res_ready = 1'b1;
        push_cmd(4'b0000, 4'd9, 4'd5, 1'b1, ok);
        tick();
        checks++; if (bus.operand1 !== 4'd0) begin errors++; $display("FAIL rst_acc_operand1 got=%h want=0", bus.operand1); end
        get_result(ok, d, op, e);
        checks++; if (ok !== 1'b1 || d !== 8'h05) begin errors++; $display("FAIL rst_acc_result got=ok%b d%h want=ok1 d05", ok, d); end
        for (int i = 0; i < 6; i++) tick();
        checks++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL rst_no_stale got=v%b busy%b want=v0 busy0", bus.res_valid, bus.busy); end
        acc_m = 8'h05;
    endtask

    task automatic test_random;
        int collected = 0;
        int pushed = 0;
        localparam int NCMD = 30;
        fork
            begin : pusher
                for (int i = 0; i < NCMD; i++) begin
                    cmd_s c;
                    bit ok;
                    c.op = 4'($urandom_range(0, 7));
                    c.a  = N'($urandom);
                    c.b  = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
                    c.ua = 1'($urandom_range(0, 1));
                    for (int g = $urandom_range(0, 2); g > 0; g--) tick();
                    bus.cmd_op = c.op; bus.cmd_a = c.a; bus.cmd_b = c.b; bus.cmd_use_acc = c.ua;
                    bus.cmd_valid = 1'b1;
                    ok = 1'b0;
                    for (int n = 0; n < 200; n++) begin
                        if (bus.cmd_ready) begin
                            q_cmd.push_back(c); ok = 1'b1; pushed++;
                            tick();
                            break;
                        end
                        tick();
                    end
                    bus.cmd_valid = 1'b0;
                    if (!ok) break;
                end
            end
            begin : collector
                for (int t = 0; t < 3000 && collected < NCMD; t++) begin
                    bus.res_ready = 1'($urandom_range(0, 1));
                    if (bus.res_valid && bus.res_ready) begin
                        if (q_cmd.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL rnd_unexpected got=result d%h want=none", bus.res_data);
                        end else begin
                            cmd_s c;
                            logic [N-1:0] o1;
                            logic err;
                            logic [W-1:0] exp;
                            c   = q_cmd.pop_front();
                            o1  = c.ua ? acc_m[N-1:0] : c.a;
                            err = (c.op == 4'd3 || c.op == 4'd4) && (c.b == 0);
                            exp = err ? '0 : alu_ref(c.op, o1, c.b);
                            checks++;
                            if (bus.res_data !== exp || bus.res_op !== c.op || bus.res_err !== err) begin
                                errors++;
                                $display("FAIL rnd_result%0d got=d%h op%h e%b want=d%h op%h e%b",
                                         collected, bus.res_data, bus.res_op, bus.res_err, exp, c.op, err);
                            end
                            acc_m = exp;
                        end
                        collected++;
                    end
                    tick();
                end
            end
        join
        bus.res_ready = 1'b1;
        checks++; if (collected != NCMD || pushed != NCMD) begin
            errors++; $display("FAIL rnd_count got=%0d/%0d want=%0d/%0d", pushed, collected, NCMD, NCMD); end
    endtask

    initial begin
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0;
        bus.cmd_use_acc = 1'b0; bus.res_ready = 1'b0;
        test_reset();
        test_single_add();
        test_acc_chain();
        test_div_zero();
        test_back_to_back();
        test_reset_mid_resp();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Command-side initiator for the team's combinational N-bit ALU.
- Buffers ALU commands in a small FIFO and drives registered operand1/operand2/operation onto the ALU ports.
- Captures alu_out one cycle later and presents it on a valid/ready result port.
- Keeps an accumulator so chained operations can take operand1 from the previous result. The divide/modulo-by-zero case is handled locally and never issued to the ALU.

Parameters:
N, 4, operand width; ALU result width is 2N
DEPTH, 4, command FIFO entries (power of 2, >=2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept (= not full)
cmd_op  input  4  ALU operation code
cmd_a  input  N  operand1 (ignored when cmd_use_acc=1)
cmd_b  input  N  operand2
cmd_use_acc  input  1  take operand1 from acc[N-1:0]
operand1  output  N  registered ALU operand1
operand2  output  N  registered ALU operand2
operation  output  4  registered ALU opcode
alu_out  input  2N  combinational ALU result
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_data  output  2N  captured result
res_op  output  4  opcode that produced res_data
res_err  output  1  divide/modulo by zero
busy  output  1  state != IDLE or FIFO non-empty

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset effects: FIFO flushed, state=IDLE, acc=0.
  - Outputs after reset: operand1/operand2/operation/res_data/res_op=0; res_valid=0, res_err=0, busy=0, cmd_ready=1.
  - Reset in any state, including mid-handshake, discards the in-flight command and all queued commands. The result is not delivered.
- Push: at the edge where cmd_valid & cmd_ready. The entry stored is {op, a, b, use_acc}.
- cmd_ready is derived only from registered count (count<DEPTH). A same-edge pop does not allow a push when full. Push and pop on the same edge when not full: count unchanged.
- FSM, IDLE -> DRIVE -> RESP -> IDLE:
  - IDLE: if FIFO non-empty, pop the head at the edge.
    - Load operation=op and operand2=b.
    - operand1 = use_acc ? acc[N-1:0] : a, using acc's value at that edge.
    - Compute err = (op==4'b0011 or op==4'b0100) and b==0.
    - Go to DRIVE.
  - DRIVE: one cycle for the ALU to settle. At the next edge:
    - res_data = err ? 0 : alu_out; res_op=operation; res_err=err; res_valid=1.
    - Go to RESP.
  - RESP: hold res_* stable while res_ready=0. At the edge where res_valid & res_ready:
    - res_valid=0, acc=res_data, state=IDLE.
    - No pop on that same edge.
- Latency: with FSM idle and FIFO empty, res_valid rises 2 edges after the push edge. Sustained throughput is 1 result per 3 cycles with res_ready held high.
- Ordering: results are delivered strictly in command order. Nothing is dropped under backpressure.
- Error results still update acc (acc=0). res_err is valid only while res_valid=1 and clears with it.
- operand1/operand2/operation hold their last values outside DRIVE; they change only on a pop edge.
- Widths:
  - acc is 2N bits; only acc[N-1:0] is fed back (truncation is intended).
  - No sign handling; all values are unsigned.
- Capacity: at most DEPTH queued plus 1 in flight (DRIVE/RESP). Count wraps are illegal; pointers wrap modulo DEPTH.

Test Plan:
1. Reset, no stimulus -> cmd_ready=1, res_valid=0, busy=0, operand1=operand2=operation=0, res_data=0.
2. Push op=0000 a=7 b=9, res_ready=1 -> operation=0000, operand1=7, operand2=9 one edge after push; res_valid=1 two edges after push with res_data=8'h10, res_op=0000, res_err=0.
3. Accumulator chain:
   - Push op=0010 a=15 b=15 -> res_data=8'hE1.
   - Then push op=0000 b=2 use_acc=1 (cmd_a=9 ignored) -> operand1=1, res_data=8'h03.
4. Divide-by-zero:
   - Push op=0011 a=9 b=0 -> res_err=1, res_data=0.
   - Then op=0011 a=9 b=2 -> res_err=0, res_data=4.
   - Then op=0100 a=9 b=0 use_acc=0 -> res_err=1.
5. Backpressure, DEPTH=4, res_ready=0:
   - Push 6 back-to-back ADD commands (a=i, b=1, i=1..6) -> cmd 1 in RESP, cmds 2-5 queued; cmd_ready=0 after the 5th accepted; cmd 6 stalls.
   - Then res_ready=1 -> results 2,3,4,5,6,7 in order, each res_valid pulse 3 cycles apart.
6. Assert rst for one cycle while in RESP with 3 commands queued -> next cycle res_valid=0, busy=0, cmd_ready=1. A following op=0000 use_acc=1 b=5 yields operand1=0, res_data=5.
